// File: rtl/imem_loader.sv
// Instruction-memory writer: takes a length-prefixed little-endian byte stream,
// writes it word by word from byte address 0 and holds the core in reset until done.
module imem_loader #(
  parameter int unsigned n       = 32,
  parameter int unsigned width   = 32,
  parameter int unsigned entries = 265
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             we,
  output logic [n-1:0]     wa,
  output logic [width-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cpu_rst,
  output logic [15:0]      words_loaded
);

  localparam int unsigned CntW = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  len_q, len_d;
  logic [CntW-1:0]  idx_q, idx_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [width-1:0] word_q, word_d;
  logic [n-1:0]     wa_q, wa_d;
  logic [width-1:0] wd_q, wd_d;
  logic             we_q, we_d;
  logic             rx_ready_q, rx_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             xfer;
  logic [CntW-1:0]  hdr_len;

  assign xfer    = rx_valid && rx_ready_q;
  assign hdr_len = {rx_data, len_q[7:0]};

  // Next-state, datapath and flag decode; flags are registered from state_d so
  // they always line up with the state register.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    wa_d       = wa_q;
    wd_d       = wd_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN0;
          len_d      = '0;
          idx_d      = '0;
          byte_cnt_d = '0;
        end
      end
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d = hdr_len;
          if (hdr_len == '0)                       state_d = S_DONE;
          else if (hdr_len > CntW'(entries))       state_d = S_ERR;
          else                                     state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          // First byte ends up in the low lane after four shifts.
          word_d     = {rx_data, word_q[width-1:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
            wd_d    = word_d;
            wa_d    = n'({idx_q, 2'b00});
          end
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + CntW'(1);
        state_d = ((idx_q + CntW'(1)) == len_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
    busy_d     = rx_ready_d || (state_d == S_WRITE);
    we_d       = (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    cpu_rst_d  = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      wa_q       <= '0;
      wd_q       <= '0;
      we_q       <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign we           = we_q;
  assign wa           = wa_q;
  assign wd           = wd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign cpu_rst      = cpu_rst_q;
  assign words_loaded = idx_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus random images,
// with expected memory writes derived from the image contents.
module tb_imem_loader;

  localparam int unsigned NA      = 32;
  localparam int unsigned WW      = 32;
  localparam int unsigned ENTRIES = 265;

  logic          clk = 1'b0;
  logic          rst, start, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, we, busy, done, err, cpu_rst;
  logic [NA-1:0] wa;
  logic [WW-1:0] wd;
  logic [15:0]   words_loaded;

  int tests = 0;
  int fails = 0;
  logic [63:0] obs_q[$];
  logic        prev_we = 1'b0;

  imem_loader #(.n(NA), .width(WW), .entries(ENTRIES)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done),
    .err(err), .cpu_rst(cpu_rst), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record every write; a write cycle must never also accept a byte.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      obs_q.push_back({wa, wd});
      check("ready_low_during_write", 64'(rx_ready), 64'd0);
      check("we_single_cycle", 64'(prev_we), 64'd0);
    end
    prev_we <= we;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Offer each byte until it is taken; gap_pct percent of offers are idle cycles.
  task automatic send_bytes(input logic [7:0] b[$], input int unsigned gap_pct);
    foreach (b[i]) begin
      bit taken = 1'b0;
      int budget = 0;
      while (!taken) begin
        @(negedge clk);
        if ($urandom_range(99) < gap_pct) rx_valid = 1'b0;
        else begin
          rx_valid = 1'b1;
          rx_data  = 8'($urandom) ;
          rx_data  = b[i];
        end
        if (rx_valid && rx_ready) taken = 1'b1;
        budget++;
        if (budget > 400) begin
          check("byte_accept_timeout", 64'd0, 64'd1);
          rx_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk) rx_valid = 1'b0;
  endtask

  task automatic build_stream(input logic [31:0] w[$], input int unsigned nhdr,
                              output logic [7:0] s[$]);
    s.delete();
    s.push_back(8'(nhdr));
    s.push_back(8'(nhdr >> 8));
    foreach (w[i]) for (int k = 0; k < 4; k++) s.push_back(8'(w[i] >> (8 * k)));
  endtask

  task automatic wait_final();
    for (int k = 0; k < 50 && !(done || err); k++) @(negedge clk);
    check("load_settles", 64'(done || err), 64'd1);
  endtask

  // Full load of a legal image, checked against the writes the image implies.
  task automatic run_image(input string tag, input logic [31:0] w[$], input int unsigned gap_pct);
    logic [7:0] s[$];
    pulse_start();
    obs_q.delete();
    build_stream(w, w.size(), s);
    send_bytes(s, gap_pct);
    wait_final();
    check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(w.size()));
    foreach (w[i]) if (i < obs_q.size())
      check({tag, "_write"}, obs_q[i], {32'(i * 4), w[i]});
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ready"}, 64'(rx_ready), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'(w.size()));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(rx_ready), 64'd0);
    check({tag, "_we"}, 64'(we), 64'd0);
    check({tag, "_wa"}, 64'(wa), 64'd0);
    check({tag, "_wd"}, 64'(wd), 64'd0);
    check({tag, "_flags"}, {61'd0, busy, done, err}, 64'd0);
    check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    logic [31:0] prog[$];
    logic [31:0] w[$];
    logic [7:0]  s[$];

    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(rx_ready), 64'd0);

    // Nominal two-word program with write latency checks.
    prog = '{32'h00A00513, 32'h00B00593};
    pulse_start();
    obs_q.delete();
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
    send_bytes(s, 0);
    check("nom_we0", {31'd0, we, wa}, {32'd1, 32'h0});
    check("nom_wd0", 64'(wd), 64'h00A00513);
    s = '{8'h93, 8'h05, 8'hB0, 8'h00};
    send_bytes(s, 0);
    check("nom_we1", {31'd0, we, wa}, {32'd1, 32'h4});
    check("nom_wd1", 64'(wd), 64'h00B00593);
    wait_final();
    check("nom_nwrites", 64'(obs_q.size()), 64'd2);
    check("nom_done", {60'd0, done, err, cpu_rst, busy}, 64'b1000);
    check("nom_words", 64'(words_loaded), 64'd2);

    // Same program under random valid gaps.
    run_image("gaps", prog, 50);

    // Zero-length image completes right after the header.
    pulse_start();
    obs_q.delete();
    s = '{8'h00, 8'h00};
    send_bytes(s, 0);
    check("zero_done", {61'd0, done, cpu_rst, err}, 64'b100);
    check("zero_words", 64'(words_loaded), 64'd0);
    repeat (3) @(negedge clk);
    check("zero_nwrites", 64'(obs_q.size()), 64'd0);

    // Oversized header goes to error without writes, then recovers.
    pulse_start();
    obs_q.delete();
    s = '{8'h0A, 8'h01};
    send_bytes(s, 0);
    check("ovf_err", {61'd0, err, cpu_rst, done}, 64'b110);
    check("ovf_ready", 64'(rx_ready), 64'd0);
    repeat (5) @(negedge clk);
    check("ovf_nwrites", 64'(obs_q.size()), 64'd0);
    w = '{32'($urandom)};
    run_image("ovf_recover", w, 0);

    // Reset partway through the data phase.
    pulse_start();
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93};
    send_bytes(s, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    obs_q.delete();
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_nwrites", 64'(obs_q.size()), 64'd0);
    check("midrst_idle", {62'd0, busy, rx_ready}, 64'd0);
    run_image("reload", prog, 0);

    // Random images of random length.
    for (int t = 0; t < 3; t++) begin
      w.delete();
      for (int i = 0; i < int'($urandom_range(12, 1)); i++) w.push_back($urandom);
      run_image("rand", w, 30);
    end

    // Largest legal image.
    w.delete();
    for (int i = 0; i < int'(ENTRIES); i++) w.push_back(32'(i));
    run_image("full", w, 0);
    if (obs_q.size() > 0)
      check("full_last_wa", 64'(obs_q[obs_q.size() - 1] >> 32), 64'h420);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
